ifetch: RTL

Instruction fetch stage for the RISC-V core. It holds the fetch PC, issues one word read at a time to instruction memory, and captures the returned word into the instruction register. That register drives the immediate generator and the decoder over a valid/ready handshake. Branch and jump redirects from execute are handled with a drain state that discards the in-flight response.

---
 rtl/ifetch.sv | 100 ++++++++++
 1 files changed

// File: rtl/ifetch.sv
// Instruction fetch stage: one outstanding imem read, instruction register
// handed downstream over valid/ready, redirects drain the in-flight response.
module ifetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ir,
  output logic [31:0] ir_pc,
  output logic        ir_valid,
  input  logic        ir_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_WAIT,
    S_HOLD,
    S_DRAIN
  } state_e;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] ir_pc_q, ir_pc_d;
  logic        irv_q, irv_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= NOP;
      ir_pc_q <= RESET_PC;
      irv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      ir_pc_q <= ir_pc_d;
      irv_q   <= irv_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    ir_pc_d = ir_pc_q;
    irv_d   = irv_q;
    unique case (state_q)
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        if (imem_rvalid) begin
          ir_d    = imem_rdata;
          ir_pc_d = pc_q;
          irv_d   = 1'b1;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (irv_q && ir_ready) begin
          irv_d   = 1'b0;
          pc_d    = pc_q + 32'd4;
          state_d = S_FETCH;
        end
      end
      S_DRAIN: begin
        if (imem_rvalid) state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    // Redirect overrides everything; a response still owed sends us to DRAIN.
    if (redirect) begin
      pc_d    = {redirect_pc[31:2], 2'b00};
      ir_d    = ir_q;
      ir_pc_d = ir_pc_q;
      irv_d   = 1'b0;
      unique case (state_q)
        S_FETCH: state_d = S_DRAIN;
        S_WAIT:  state_d = imem_rvalid ? S_FETCH : S_DRAIN;
        S_DRAIN: state_d = imem_rvalid ? S_FETCH : S_DRAIN;
        default: state_d = S_FETCH;
      endcase
    end
  end

  assign imem_req  = (state_q == S_FETCH) && !rst;
  assign imem_addr = pc_q;
  assign ir        = ir_q;
  assign ir_pc     = ir_pc_q;
  assign ir_valid  = irv_q;

endmodule
